// File: rtl/gate_vector_driver.sv
// Drives the four (a,b) operand pairs into a logic-gates stage, samples its
// 7-bit result per pair and reports a verdict. Optional macro:
// GATE_VECTOR_DRIVER_STOP_ON_ERR_EN ends the sweep at the first miscompare.
module gate_vector_driver #(
  parameter int unsigned HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] gate_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec,
  output logic [1:0] vec_idx,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     r_state;
  logic [3:0] r_hold;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic [1:0] r_vec;

  logic [6:0] w_exp;
  logic       w_miss;
  logic [3:0] w_err_next;
  logic       w_last;
  logic       w_stop;
  logic [1:0] w_vec_inc;

  // Gate results expected for each vector, bit order {and,or,not_a,nand,nor,xor,xnor}.
  always_comb begin
    w_exp = 7'h1D;
    case (r_vec)
      2'd0: w_exp = 7'h1D;
      2'd1: w_exp = 7'h2A;
      2'd2: w_exp = 7'h3A;
      2'd3: w_exp = 7'h61;
      default: w_exp = 7'h1D;
    endcase
  end

  assign w_miss     = (gate_in != w_exp);
  assign w_err_next = r_err | (w_miss ? (4'b0001 << r_vec) : 4'b0000);
  assign w_last     = (r_vec == 2'd3);
  assign w_vec_inc  = r_vec + 2'd1;

`ifdef GATE_VECTOR_DRIVER_STOP_ON_ERR_EN
  assign w_stop = w_last || w_miss;
`else
  assign w_stop = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= 4'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_vec   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_hold  <= 4'd0;
            r_busy  <= 1'b1;
            r_vec   <= 2'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_err   <= 4'd0;
            r_pass  <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (r_hold == HOLD_LAST) begin
            r_hold  <= 4'd0;
            r_state <= S_SAMPLE;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_err <= w_err_next;
          if (w_stop) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 4'd0);
          end else begin
            // The vector index doubles as the operand pair: a = idx[0], b = idx[1].
            r_vec   <= w_vec_inc;
            r_a     <= w_vec_inc[0];
            r_b     <= w_vec_inc[1];
            r_state <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_vec   = r_err;
  assign vec_idx   = r_vec;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gate_vector_driver.sv
// Bench for gate_vector_driver: a cycle-count model of the sweep checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_gate_vector_driver;
  localparam int HOLD = 2;
  localparam int T    = HOLD + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a, b, busy, done, pass;
  logic [6:0] gate_in;
  logic [3:0] err_vec;
  logic [1:0] vec_idx, dbg_state;
  logic [6:0] and_mask = 7'h7F;
  logic [6:0] xor_mask = 7'h00;

  gate_vector_driver #(.HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .gate_in(gate_in),
    .busy(busy), .done(done), .pass(pass), .err_vec(err_vec), .vec_idx(vec_idx),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Gates stage with injectable faults.
  assign gate_in = ({a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)} & and_mask) ^ xor_mask;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] golden(input int k);
    logic x, y;
    x = k[0];
    y = k[1];
    return {x & y, x | y, ~x, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
  endfunction

  // Behavioural model: phase 0 idle, 1 running (m_t = cycle number since the
  // accepting edge), 2 done cycle.
  int         edge_n = 0;
  int         acc_edge = 0;
  int         m_phase = 0;
  int         m_t = 0;
  int         m_k = 0;
  logic [3:0] m_err = 4'd0;
  logic       m_pass = 1'b0;

  int         mk_now;
  logic       m_sample, m_miss, m_stop;
  logic [3:0] m_err_nx;

  always_comb begin
    mk_now   = (m_t > 0) ? (m_t - 1) / T : 0;
    m_sample = (m_phase == 1) && (m_t % T == 0);
    m_miss   = (gate_in !== golden(mk_now));
    m_err_nx = m_err | ((m_sample && m_miss) ? (4'b0001 << mk_now) : 4'b0000);
`ifdef GATE_VECTOR_DRIVER_STOP_ON_ERR_EN
    m_stop   = m_sample && ((mk_now == 3) || m_miss);
`else
    m_stop   = m_sample && (mk_now == 3);
`endif
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_t     <= 0;
      m_k     <= 0;
      m_err   <= 4'd0;
      m_pass  <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase  <= 1;
          m_t      <= 1;
          m_err    <= 4'd0;
          m_pass   <= 1'b0;
          acc_edge <= edge_n + 1;
        end
        1: begin
          if (m_sample) m_err <= m_err_nx;
          if (m_stop) begin
            m_phase <= 2;
            m_k     <= mk_now;
            m_pass  <= (m_err_nx == 4'd0);
          end else begin
            m_t <= m_t + 1;
          end
        end
        default: begin
          m_phase <= 0;
          m_t     <= 0;
        end
      endcase
    end
  end

  int   e_k;
  logic e_a, e_b, e_busy, e_done;
  always_comb begin
    e_k    = (m_phase == 2) ? m_k : mk_now;
    e_a    = 1'b0;
    e_b    = 1'b0;
    e_busy = (m_phase != 0);
    e_done = (m_phase == 2);
    if (m_phase != 0) begin
      e_a = e_k[0];
      e_b = e_k[1];
    end
  end

  // Scoreboard for hand-computed done cycles, plus per-cycle model compare.
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         last_done_edge = 0;
  int         prev_done_edge = 0;
  logic [1:0] last_done_vec = 2'd0;
  logic       rec = 1'b0;
  logic [1:0] ab_q[$];

  always @(negedge clk) begin
    check("outputs_vs_model", {a, b, busy, done, pass, err_vec},
          {e_a, e_b, e_busy, e_done, m_pass, m_err});
    if (e_busy) check("vec_idx_vs_model", vec_idx, e_k[1:0]);
    if (rec && busy && !done) ab_q.push_back({a, b});
    if (done && rst_n) begin
      done_cnt++;
      prev_done_edge = last_done_edge;
      last_done_edge = edge_n;
      last_done_vec  = vec_idx;
      if (exp_q.size() > 0) check("done_cycle", edge_n - acc_edge + 1, exp_q.pop_front());
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({"idle_timeout_", name}, ok, 1);
  endtask

  initial begin
    int base;
    bit ok;
    int seen;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {a, b, busy, done, pass, err_vec, vec_idx}, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;

    // Clean sweep: done at cycle 13, pass, three cycles per pair
    exp_q.push_back(8'd13);
    rec = 1'b1;
    pulse_start();
    wait_idle("clean", 60);
    rec = 1'b0;
    check("clean_pass", pass, 1);
    check("clean_err", err_vec, 4'b0000);
    check("clean_ab_len", ab_q.size(), 12);
    for (int i = 0; i < 12 && i < ab_q.size(); i++)
      check("clean_ab_seq", ab_q[i], {1'(((i / 3) % 2)), 1'((i / 3) / 2)});

    // xor output stuck at 0
    and_mask = 7'h7D;
`ifdef GATE_VECTOR_DRIVER_STOP_ON_ERR_EN
    exp_q.push_back(8'd7);
`else
    exp_q.push_back(8'd13);
`endif
    pulse_start();
    wait_idle("xor_stuck", 60);
    check("xor_pass", pass, 0);
`ifdef GATE_VECTOR_DRIVER_STOP_ON_ERR_EN
    check("xor_err", err_vec, 4'b0010);
    check("xor_done_vec", last_done_vec, 2'd1);
`else
    check("xor_err", err_vec, 4'b0110);
    check("xor_done_vec", last_done_vec, 2'd3);
`endif
    repeat (3) @(negedge clk);
    check("xor_verdict_held", {pass, err_vec}, {1'b0, err_vec});
    and_mask = 7'h7F;

    // start held high: back-to-back sweeps, second accepted on the IDLE cycle
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd13);
    base = done_cnt;
    seen = 0;
    ok = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) seen++;
      if (seen == 2) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("held_two_dones", ok, 1);
    wait_idle("held", 10);
    check("held_done_spacing", last_done_edge - prev_done_edge, 14);
    check("held_done_count", done_cnt - base, 2);

    // Reset during vector 2 aborts the sweep
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vec_idx == 2'd2) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_vec2", ok, 1);
    base = done_cnt;
    #2 rst_n = 1'b0;
    #1 check("midsweep_reset_outputs", {a, b, busy, done, pass, err_vec, vec_idx}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);
    exp_q.push_back(8'd13);
    pulse_start();
    wait_idle("after_reset", 60);
    check("after_reset_pass", pass, 1);

    // start pulses during DRIVE and DONE are ignored
    base = done_cnt;
    exp_q.push_back(8'd13);
    pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("ignore_reach_done", ok, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ignore_no_retrigger", busy, 0);
    check("ignore_one_done", done_cnt - base, 1);
    check("ignore_pass", pass, 1);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          and_mask = 7'h7F;
          xor_mask = 7'h00;
        end else begin
          and_mask = 7'h7F & ~(7'h01 << $urandom_range(0, 6));
          xor_mask = ($urandom_range(0, 2) == 0) ? 7'(7'h01 << $urandom_range(0, 6)) : 7'h00;
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
    wait_idle("random_end", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
